signadder_arbiter: RTL



---
 rtl/signadder_arb_pkg.sv | 16 +
 rtl/signadder_rr_pick.sv | 37 +++
 rtl/signadder_arbiter.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/signadder_arb_pkg.sv
// Shared definitions for the signed-adder arbiter: FSM state encoding and
// the requester-index width helper.
package signadder_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    GRANT  = 2'b01,
    RESULT = 2'b10
  } arbState_e;

  // A single requester still needs a one-bit index so res_id never collapses.
  function automatic int calcIdW(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/signadder_rr_pick.sv
// Combinational round-robin picker: returns the first set request found
// scanning upward from i_ptr, wrapping around to index 0.
module signadder_rr_pick #(
  parameter int reqNumber = 4,
  parameter int idW       = 2
) (
  input  logic [reqNumber-1:0] i_req,
  input  logic [idW-1:0]       i_ptr,
  output logic                 o_found,
  output logic [idW-1:0]       o_winner
);

  int w_dist;
  int w_best;

  // The winner is the requester at the smallest wrapped distance from the pointer.
  always_comb begin
    o_winner = '0;
    w_dist   = 0;
    w_best   = reqNumber;
    for (int i = 0; i < reqNumber; i++) begin
      if (i_req[i]) begin
        w_dist = i - int'(i_ptr);
        if (w_dist < 0) begin
          w_dist = w_dist + reqNumber;
        end
        if (w_dist < w_best) begin
          w_best   = w_dist;
          o_winner = idW'(i);
        end
      end
    end
  end

  assign o_found = |i_req;

endmodule

// File: rtl/signadder_arbiter.sv
// Round-robin arbiter sharing one signed adder among reqNumber requesters.
// Define SIGNADDER_ARB_SAT_EN to saturate Sum on signed overflow.
module signadder_arbiter
  import signadder_arb_pkg::*;
#(
  parameter  int bitNumber = 8,
  parameter  int reqNumber = 4,
  localparam int idW       = calcIdW(reqNumber)
) (
  input  logic                           clk1,
  input  logic                           rst,
  input  logic [reqNumber-1:0]           req,
  input  logic [reqNumber*bitNumber-1:0] A_flat,
  input  logic [reqNumber*bitNumber-1:0] B_flat,
  output logic [reqNumber-1:0]           gnt,
  output logic                           busy,
  output logic                           res_valid,
  output logic [idW-1:0]                 res_id,
  output logic [bitNumber-1:0]           Sum,
  output logic                           Carry,
  output logic                           Overflow
);

  arbState_e            r_state, w_stateNxt;
  logic [idW-1:0]       r_ptr, w_ptrNxt;
  logic [idW-1:0]       r_winner, w_winnerNxt;
  logic [bitNumber-1:0] r_a, w_aNxt, r_b, w_bNxt;
  logic [reqNumber-1:0] r_gnt, w_gntNxt;
  logic                 r_busy, w_busyNxt;
  logic                 r_valid, w_validNxt;
  logic [idW-1:0]       r_id, w_idNxt;
  logic [bitNumber-1:0] r_sum, w_sumNxt;
  logic                 r_carry, w_carryNxt;
  logic                 r_ovf, w_ovfNxt;

  logic                 w_found;
  logic [idW-1:0]       w_pick;
  logic [bitNumber-1:0] w_aSel, w_bSel;
  logic [bitNumber:0]   w_full;
  logic [bitNumber-1:0] w_rawSum, w_sumOut;
  logic                 w_carry, w_ovf;

  signadder_rr_pick #(
    .reqNumber (reqNumber),
    .idW       (idW)
  ) u_pick (
    .i_req    (req),
    .i_ptr    (r_ptr),
    .o_found  (w_found),
    .o_winner (w_pick)
  );

  always_comb begin
    w_aSel = '0;
    w_bSel = '0;
    for (int i = 0; i < reqNumber; i++) begin
      if (w_pick == idW'(i)) begin
        w_aSel = A_flat[i*bitNumber +: bitNumber];
        w_bSel = B_flat[i*bitNumber +: bitNumber];
      end
    end
  end

  assign w_full   = {1'b0, r_a} + {1'b0, r_b};
  assign w_rawSum = w_full[bitNumber-1:0];
  assign w_carry  = w_full[bitNumber];
  assign w_ovf    = (r_a[bitNumber-1] == r_b[bitNumber-1]) &&
                    (w_rawSum[bitNumber-1] != r_a[bitNumber-1]);

`ifdef SIGNADDER_ARB_SAT_EN
  // Clamp toward the sign of the operands; both operands share a sign on overflow.
  assign w_sumOut = !w_ovf          ? w_rawSum :
                    r_a[bitNumber-1] ? {1'b1, {(bitNumber-1){1'b0}}} :
                                       {1'b0, {(bitNumber-1){1'b1}}};
`else
  assign w_sumOut = w_rawSum;
`endif

  always_comb begin
    w_stateNxt  = r_state;
    w_ptrNxt    = r_ptr;
    w_winnerNxt = r_winner;
    w_aNxt      = r_a;
    w_bNxt      = r_b;
    w_gntNxt    = '0;
    w_validNxt  = 1'b0;
    w_idNxt     = r_id;
    w_sumNxt    = r_sum;
    w_carryNxt  = r_carry;
    w_ovfNxt    = r_ovf;
    case (r_state)
      IDLE: begin
        if (w_found) begin
          w_stateNxt  = GRANT;
          w_winnerNxt = w_pick;
          w_aNxt      = w_aSel;
          w_bNxt      = w_bSel;
          w_gntNxt    = reqNumber'(1) << w_pick;
        end
      end
      GRANT: begin
        w_stateNxt = RESULT;
        w_sumNxt   = w_sumOut;
        w_carryNxt = w_carry;
        w_ovfNxt   = w_ovf;
        w_validNxt = 1'b1;
        w_idNxt    = r_winner;
      end
      RESULT: begin
        w_stateNxt = IDLE;
        w_ptrNxt   = (r_winner == idW'(reqNumber - 1)) ? '0 : r_winner + idW'(1);
      end
      default: w_stateNxt = IDLE;
    endcase
    w_busyNxt = (w_stateNxt != IDLE);
  end

  always_ff @(posedge clk1) begin
    if (rst) begin
      r_state  <= IDLE;
      r_ptr    <= '0;
      r_winner <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_gnt    <= '0;
      r_busy   <= 1'b0;
      r_valid  <= 1'b0;
      r_id     <= '0;
      r_sum    <= '0;
      r_carry  <= 1'b0;
      r_ovf    <= 1'b0;
    end else begin
      r_state  <= w_stateNxt;
      r_ptr    <= w_ptrNxt;
      r_winner <= w_winnerNxt;
      r_a      <= w_aNxt;
      r_b      <= w_bNxt;
      r_gnt    <= w_gntNxt;
      r_busy   <= w_busyNxt;
      r_valid  <= w_validNxt;
      r_id     <= w_idNxt;
      r_sum    <= w_sumNxt;
      r_carry  <= w_carryNxt;
      r_ovf    <= w_ovfNxt;
    end
  end

  assign gnt       = r_gnt;
  assign busy      = r_busy;
  assign res_valid = r_valid;
  assign res_id    = r_id;
  assign Sum       = r_sum;
  assign Carry     = r_carry;
  assign Overflow  = r_ovf;

endmodule
